// File: rtl/tremolo_mc_pkg.sv
// Shared types and constants for the multi-channel tremolo / auto-pan stage.
// Optional gain slewing is enabled by defining TREMOLO_MC_SMOOTH_EN.
package tremolo_mc_pkg;

    typedef enum logic [1:0] {
        TRI  = 2'd0,
        SQR  = 2'd1,
        RAMP = 2'd2,
        NONE = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GAIN_W       = 9;
    localparam int GAIN_MAX     = 511;
    localparam int PHASE_BYTE_W = 8;

    // Full-scale gain minus the depth-scaled modulator; level 0 leaves the signal at 511/512.
    function automatic logic [GAIN_W-1:0] target_gain(input logic [GAIN_W-1:0] m,
                                                      input logic [7:0]        level);
        logic [GAIN_W+7:0] scaled;
        scaled = {8'b0, m} * {9'b0, level};
        return GAIN_W'(GAIN_MAX) - GAIN_W'(scaled >> 8);
    endfunction

endpackage

// File: rtl/tremolo_mc_if.sv
// Control, sample and status bundle for tremolo_mc (all signals in the clk_i domain).
// Handshake: sample_tick_i is a one-cycle strobe; valid_o pulses once per accepted tick.
interface tremolo_mc_if
    import tremolo_mc_pkg::*;
#(
    parameter int DW = 16,
    parameter int CH = 2
);
    logic               sample_tick_i;
    logic [7:0]         frequency_number_i;
    logic [7:0]         level_i;
    logic [1:0]         wave_sel_i;
    logic [7:0]         spread_i;
    logic               enable_i;
    logic [CH*DW-1:0]   data_i;
    logic [CH*DW-1:0]   data_o;
    logic               valid_o;
    logic               busy_o;
    logic               overrun_o;
    state_t             dbg_state;

    modport slave (
        input  sample_tick_i, frequency_number_i, level_i, wave_sel_i, spread_i,
               enable_i, data_i,
        output data_o, valid_o, busy_o, overrun_o, dbg_state
    );

    modport master (
        output sample_tick_i, frequency_number_i, level_i, wave_sel_i, spread_i,
               enable_i, data_i,
        input  data_o, valid_o, busy_o, overrun_o, dbg_state
    );
endinterface

// File: rtl/tremolo_mc_wave.sv
// LFO shaper: 8-bit phase byte and waveform select to a 9-bit modulator value.
module tremolo_mc_wave
    import tremolo_mc_pkg::*;
(
    input  logic [PHASE_BYTE_W-1:0] phase,
    input  wave_t                   wave,
    output logic [GAIN_W-1:0]       m
);
    always_comb begin
        m = '0;
        case (wave)
            TRI:     m = {(phase[7] ? ~phase[6:0] : phase[6:0]), 2'b00};
            SQR:     m = phase[7] ? 9'd511 : 9'd0;
            RAMP:    m = {phase, 1'b0};
            default: m = '0;
        endcase
    end
endmodule

// File: rtl/tremolo_mc.sv
// Time-multiplexed tremolo / auto-pan: one shared multiplier, one channel per clock.
// Define TREMOLO_MC_SMOOTH_EN to slew each channel's gain by at most SLEW_STEP per tick.
module tremolo_mc
    import tremolo_mc_pkg::*;
#(
    parameter int    DW                  = 16,
    parameter int    CH                  = 2,
    parameter int    PHASE_W             = 16,
    parameter string FREQ_TABLE_FILE     = "",
    parameter int    FREQ_DIVISOR_FACTOR = 1,
    parameter int    SLEW_STEP           = 4
) (
    input logic         clk_i,
    input logic         arst_n_i,
    tremolo_mc_if.slave bus
);
    localparam int KW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = DW + GAIN_W;

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [PHASE_W-1:0]     phase, inc_raw, inc;
    state_t                 state;
    logic [KW-1:0]          k;
    logic [CH*DW-1:0]       cap_data, res, res_next, data_q;
    logic [(CH+1)*DW-1:0]   res_cat;
    logic [7:0]             cap_level, cap_spread, phase_byte;
    wave_t                  cap_wave;
    logic                   cap_en, valid_q, busy_q, overrun_q;
    logic [GAIN_W-1:0]      wave_m, tgt, gain_use;
    logic signed [DW-1:0]   sample, ch_out;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign inc_raw = PHASE_W'(bus.frequency_number_i);
    assign inc     = inc_raw >> (FREQ_DIVISOR_FACTOR - 1);

    // The LFO keeps running on every tick, accepted or not, so overruns never bend its rate.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                 phase <= '0;
        else if (bus.sample_tick_i) phase <= phase + inc;
    end

    tremolo_mc_wave u_wave (.phase(phase_byte), .wave(cap_wave), .m(wave_m));

    assign tgt    = target_gain(wave_m, cap_level);
    assign sample = cap_data[DW-1:0];

`ifdef TREMOLO_MC_SMOOTH_EN
    logic [GAIN_W-1:0] gain_q [CH];
    logic [GAIN_W-1:0] gain_cur;
    assign gain_cur = gain_q[k];

    always_comb begin
        gain_use = tgt;
        if (tgt > gain_cur)
            gain_use = ((tgt - gain_cur) > GAIN_W'(SLEW_STEP)) ? gain_cur + GAIN_W'(SLEW_STEP) : tgt;
        else
            gain_use = ((gain_cur - tgt) > GAIN_W'(SLEW_STEP)) ? gain_cur - GAIN_W'(SLEW_STEP) : tgt;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) gain_q[i] <= GAIN_W'(GAIN_MAX);
        end else if (state == CALC) begin
            gain_q[k] <= gain_use;
        end
    end
`else
    assign gain_use = tgt;
`endif

    // Product fits in DW+9 signed bits because gain < 512, so bits [DW+8:9] are the floored result.
    assign ch_out   = cap_en ? DW'((PW'(sample) * PW'({1'b0, gain_use})) >> 9) : sample;
    assign res_cat  = {ch_out, res};
    assign res_next = res_cat[(CH+1)*DW-1:DW];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            cap_data   <= '0;
            cap_level  <= '0;
            cap_spread <= '0;
            cap_wave   <= TRI;
            cap_en     <= 1'b0;
            phase_byte <= '0;
            res        <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: if (bus.sample_tick_i) begin
                    cap_data   <= bus.data_i;
                    cap_level  <= bus.level_i;
                    cap_spread <= bus.spread_i;
                    cap_wave   <= wave_t'(bus.wave_sel_i);
                    cap_en     <= bus.enable_i;
                    phase_byte <= phase[PHASE_W-1 -: PHASE_BYTE_W];
                    k          <= '0;
                    busy_q     <= 1'b1;
                    state      <= CALC;
                end
                CALC: begin
                    res        <= res_next;
                    cap_data   <= cap_data >> DW;
                    phase_byte <= phase_byte + cap_spread;
                    k          <= k + 1'b1;
                    if (k == KW'(CH - 1)) state <= DONE;
                    if (bus.sample_tick_i) overrun_q <= 1'b1;
                end
                DONE: begin
                    data_q  <= res;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                    if (bus.sample_tick_i) overrun_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_tremolo_mc.sv
// Self-checking bench for tremolo_mc: vector table, random vectors, overrun and reset sequences.
// The slewing sequence is compiled in only when TREMOLO_MC_SMOOTH_EN is defined.
module tb_tremolo_mc;
    import tremolo_mc_pkg::*;

    localparam int DW = 16;
    localparam int CH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tremolo_mc_if #(.DW(DW), .CH(CH)) bus ();
    tremolo_mc #(.DW(DW), .CH(CH)) dut (.clk_i(clk), .arst_n_i(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int valid_seen = 0;
    logic [CH*DW-1:0] exp_q [$];

    typedef struct {
        logic [1:0]        wave;
        logic [7:0]        level;
        logic [7:0]        spread;
        logic              en;
        logic signed [15:0] d0, d1, e0, e1;
    } vec_t;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] model(input logic signed [15:0] d, input logic [7:0] p,
                                                 input logic [1:0] w, input logic [7:0] lvl, input logic en);
        int t, m, g;
        longint pr;
        case (w)
            2'd0: begin
                t = p[7] ? (127 - int'(p[6:0])) : int'(p[6:0]);
                m = t * 4;
            end
            2'd1: m = p[7] ? 511 : 0;
            2'd2: m = int'(p) * 2;
            default: m = 0;
        endcase
        g  = 511 - (m * int'(lvl)) / 256;
        pr = longint'(d) * g;
        if (!en) return d;
        return 16'(pr >>> 9);
    endfunction

    always @(negedge clk) begin : monitor
        logic [CH*DW-1:0] e;
        if (rst_n && bus.valid_o) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                for (int c = 0; c < CH; c++)
                    check($sformatf("data ch%0d", c), $signed(bus.data_o[c*DW +: DW]), $signed(e[c*DW +: DW]));
            end
        end
    end

    task automatic send(input logic [1:0] w, input logic [7:0] lvl, input logic [7:0] sp, input logic en,
                        input logic [7:0] fq, input logic signed [15:0] d0, input logic signed [15:0] d1,
                        input logic signed [15:0] e0, input logic signed [15:0] e1);
        @(negedge clk);
        bus.wave_sel_i         = w;
        bus.level_i            = lvl;
        bus.spread_i           = sp;
        bus.enable_i           = en;
        bus.frequency_number_i = fq;
        bus.data_i             = {d1, d0};
        bus.sample_tick_i      = 1'b1;
        exp_q.push_back({e1, e0});
        @(negedge clk);
        bus.sample_tick_i = 1'b0;
    endtask

    task automatic await_valid(input int exp_lat);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        check("busy after tick", bus.busy_o, 1);
        for (int i = 0; i < 12; i++) begin
            if (bus.valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!seen) begin
            check("valid timeout", 0, 1);
        end else begin
            check("valid latency", lat, exp_lat);
            check("busy at valid", bus.busy_o, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [8];
        logic [1:0] w;
        logic [7:0] lvl, sp;
        logic en;
        logic signed [15:0] d0, d1;
        int vs0;

        vecs[0] = '{2'd0, 8'd255, 8'd128, 1'b1,   1000,   1000,    998,      9};
        vecs[1] = '{2'd1, 8'd255, 8'd128, 1'b1,  -1000,  -1000,   -999,     -4};
        vecs[2] = '{2'd0, 8'd255, 8'd128, 1'b0,  -1234,  32767,  -1234,  32767};
        vecs[3] = '{2'd2, 8'd128, 8'd64,  1'b1,  20000, -20000,  19960, -17461};
        vecs[4] = '{2'd3, 8'd255, 8'd50,  1'b1,  32767, -32768,  32703, -32704};
        vecs[5] = '{2'd0, 8'd0,   8'd128, 1'b1,   1000,   1000,    998,    998};
        vecs[6] = '{2'd1, 8'd255, 8'd255, 1'b1,    100,     -1,     99,     -1};
        vecs[7] = '{2'd0, 8'd255, 8'd192, 1'b1,    512,    512,    511,    260};

        bus.sample_tick_i      = 1'b0;
        bus.frequency_number_i = '0;
        bus.level_i            = '0;
        bus.wave_sel_i         = '0;
        bus.spread_i           = '0;
        bus.enable_i           = 1'b0;
        bus.data_i             = '0;

        repeat (3) @(negedge clk);
        check("reset data_o", bus.data_o, 0);
        check("reset valid_o", bus.valid_o, 0);
        check("reset busy_o", bus.busy_o, 0);
        check("reset overrun_o", bus.overrun_o, 0);
        check("reset state", bus.dbg_state, IDLE);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].wave, vecs[i].level, vecs[i].spread, vecs[i].en, 8'd0,
                 vecs[i].d0, vecs[i].d1, vecs[i].e0, vecs[i].e1);
            await_valid(4);
        end

        for (int i = 0; i < 6; i++) begin
            w   = 2'($urandom_range(0, 3));
            lvl = 8'($urandom_range(0, 255));
            sp  = 8'($urandom_range(0, 255));
            en  = ($urandom_range(0, 3) != 0);
            d0  = 16'($urandom_range(0, 65535));
            d1  = 16'($urandom_range(0, 65535));
            send(w, lvl, sp, en, 8'd0, d0, d1, model(d0, 8'd0, w, lvl, en), model(d1, sp, w, lvl, en));
            await_valid(4);
        end
        check("no overrun at legal spacing", bus.overrun_o, 0);

        // Second tick two cycles after the first: dropped, flagged, but the LFO still advances.
        @(negedge clk);
        bus.wave_sel_i         = 2'd0;
        bus.level_i            = 8'd255;
        bus.spread_i           = 8'd0;
        bus.enable_i           = 1'b1;
        bus.frequency_number_i = 8'd128;
        bus.data_i             = {16'sd1000, 16'sd1000};
        bus.sample_tick_i      = 1'b1;
        exp_q.push_back({16'sd998, 16'sd998});
        @(negedge clk);
        bus.sample_tick_i = 1'b0;
        @(negedge clk);
        bus.sample_tick_i = 1'b1;
        bus.data_i        = {16'sd5, 16'sd5};
        @(negedge clk);
        bus.sample_tick_i = 1'b0;
        check("overrun set", bus.overrun_o, 1);
        @(negedge clk);
        check("valid despite overrun", bus.valid_o, 1);
        repeat (2) @(negedge clk);
        send(2'd0, 8'd255, 8'd0, 1'b1, 8'd0, 1000, 1000,
             model(1000, 8'd1, 2'd0, 8'd255, 1'b1), model(1000, 8'd1, 2'd0, 8'd255, 1'b1));
        await_valid(4);
        check("overrun sticky", bus.overrun_o, 1);

        // Reset in the middle of CALC.
        send(2'd0, 8'd255, 8'd128, 1'b1, 8'd0, 1000, 1000, 998, 9);
        #2 rst_n = 1'b0;
        #1;
        check("midreset data_o", bus.data_o, 0);
        check("midreset valid_o", bus.valid_o, 0);
        check("midreset busy_o", bus.busy_o, 0);
        check("midreset overrun_o", bus.overrun_o, 0);
        check("midreset state", bus.dbg_state, IDLE);
        exp_q.delete();
        vs0 = valid_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no valid after midreset", valid_seen - vs0, 0);
        check("busy idle after midreset", bus.busy_o, 0);

`ifdef TREMOLO_MC_SMOOTH_EN
        begin
            int g;
            longint pr;
            send(2'd1, 8'd0, 8'd128, 1'b1, 8'd0, -1000, -1000, -999, -999);
            await_valid(4);
            g = 511;
            for (int i = 0; i < 6; i++) begin
                g  = (g - 4 > 2) ? g - 4 : 2;
                pr = -1000 * longint'(g);
                send(2'd1, 8'd255, 8'd128, 1'b1, 8'd0, -1000, -1000, -999, 16'(pr >>> 9));
                await_valid(4);
            end
        end
`endif

        repeat (2) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
